// File: rtl/sram_sched_pkg.sv
// Shared constants and helpers for the frame-buffer SRAM access scheduler.
package sram_sched_pkg;

   localparam int ADDR_W = 17;
   localparam int PIX_W  = 16;
   localparam int DQ_W   = 24;

   // Slot phases: three-cycle write slot followed by one display read cycle.
   localparam logic [1:0] PH_WR_SETUP  = 2'd0;
   localparam logic [1:0] PH_WR_STROBE = 2'd1;
   localparam logic [1:0] PH_WR_HOLD   = 2'd2;
   localparam logic [1:0] PH_RD        = 2'd3;

   // RGB565 {R,G,B} to the SRAM lane order {8'b0, B, G, R}.
   function automatic logic [DQ_W-1:0] pack_rgb565(input logic [PIX_W-1:0] px);
      return {8'h00, px[4:0], px[10:5], px[15:11]};
   endfunction

endpackage

// File: rtl/sram_wr_fifo.sv
// Small synchronous FIFO holding {addr, data} pixel writes for the SRAM write slot.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module sram_wr_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Entry storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_access_scheduler.sv
// Time-division scheduler for the single async frame-buffer SRAM: a fixed
// four-phase slot (three write phases fed by a pixel FIFO, one display read
// phase) plus double-buffer page swaps deferred to frame boundaries.
//
// Write handshake: a pixel is transferred on every rising edge where
// wr_valid and wr_ready are both high; wr_addr/wr_data must be stable while
// wr_valid is high, and wr_ready depends only on FIFO occupancy.
module sram_access_scheduler #(
   parameter int ADDR_W     = sram_sched_pkg::ADDR_W,
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2
) (
   input  logic              mco,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   input  logic              swap_req,
   input  logic              frame_start,
   output logic              swap_done,
   output logic              disp_page,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [15:0]       rd_data,
   output logic              rd_valid,
   output logic [1:0]        slot_phase,
   output logic [ADDR_W:0]   sram_addr,
   output logic [23:0]       sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [23:0]       sram_dq_in,
   output logic              sram_we_n,
   output logic              sram_oe_n
);

   import sram_sched_pkg::*;

   localparam int ENTRY_W = ADDR_W + 16;

   logic [1:0]         phase;
   logic               wr_active;
   logic               swap_pending;
   logic               fifo_push;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] fifo_head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FIFO_AW:0]   fifo_count;
   logic [ADDR_W-1:0]  head_addr;
   logic [15:0]        head_data;
   logic               swap_ok;
   logic               unused_ok;

   assign slot_phase = phase;
   assign wr_ready   = (fifo_count < (FIFO_AW+1)'(FIFO_DEPTH));
   assign fifo_push  = wr_valid & wr_ready;
   assign fifo_pop   = wr_active & (phase == PH_WR_HOLD);
   assign head_addr  = fifo_head[ENTRY_W-1:16];
   assign head_data  = fifo_head[15:0];
   // Only swap when nothing queued or in flight could still land on the new display page.
   assign swap_ok    = frame_start & swap_pending & fifo_empty & ~wr_active;
   assign unused_ok  = ^{sram_dq_in[23:16], fifo_full};

   sram_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk       (mco),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({wr_addr, wr_data}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Slot sequencer: each case arm sets the SRAM pins seen in the following phase.
   always_ff @(posedge mco) begin
      if (rst) begin
         phase       <= PH_WR_SETUP;
         wr_active   <= 1'b0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
      end else begin
         phase    <= phase + 2'd1;
         rd_valid <= 1'b0;
         case (phase)
            PH_RD: begin
               // Capture the display pixel and set up the write slot (bus turnaround, no drive).
               rd_data    <= sram_dq_in[15:0];
               rd_valid   <= 1'b1;
               sram_oe_n  <= 1'b1;
               sram_we_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               wr_active  <= ~fifo_empty;
               if (!fifo_empty) begin
                  sram_addr   <= {~disp_page, head_addr};
                  sram_dq_out <= pack_rgb565(head_data);
               end
            end
            PH_WR_SETUP: begin
               sram_we_n  <= ~wr_active;
               sram_dq_oe <= wr_active;
            end
            PH_WR_STROBE: begin
               // Rising WE latches the data; DQ keeps being driven for hold time.
               sram_we_n <= 1'b1;
            end
            default: begin
               // End of write slot: release DQ before enabling SRAM output for the read.
               wr_active  <= 1'b0;
               sram_dq_oe <= 1'b0;
               sram_we_n  <= 1'b1;
               sram_oe_n  <= 1'b0;
               sram_addr  <= {disp_page, rd_addr};
            end
         endcase
      end
   end

   // Page swap: requests merge into a pending flag, serviced at a safe frame_start.
   always_ff @(posedge mco) begin
      if (rst) begin
         disp_page    <= 1'b0;
         swap_pending <= 1'b0;
         swap_done    <= 1'b0;
      end else begin
         swap_done <= 1'b0;
         if (swap_ok) begin
            disp_page    <= ~disp_page;
            swap_done    <= 1'b1;
            swap_pending <= swap_req;
         end else if (swap_req) begin
            swap_pending <= 1'b1;
         end
      end
   end

endmodule
